// File: rtl/perf_event_sequencer.sv
// perf_event_sequencer
// Hardware front end for a 4-section Avalon-MM performance counter slave.
// Turns per-section start/stop pulses and a global clear pulse into
// single-cycle writes on the counter control slave. After a stop it can read
// back the section's 64-bit time count and 32-bit event count, and it presents
// them on a valid/ready capture port.
//
// Ports
//   clk, reset_n           system clock, asynchronous active-low reset
//   evt_start / evt_stop   per-section one-cycle start/stop request pulses
//   clr                    one-cycle global clear request pulse
//   pc_address / pc_write / pc_begintransfer / pc_writedata / pc_readdata
//                          counter slave interface (readdata has 1-cycle latency)
//   cap_valid / cap_ready / cap_section / cap_time / cap_events
//                          capture record handshake
//   ovf                    sticky: a request pulse was dropped
//   busy                   sequencer is not idle
module perf_event_sequencer #(
  parameter int unsigned NUM_SECTIONS    = 4,
  parameter bit          AUTO_SEC0       = 1'b1,
  parameter bit          CAPTURE_ON_STOP = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SECTIONS-1:0] evt_start,
  input  logic [NUM_SECTIONS-1:0] evt_stop,
  input  logic                    clr,
  output logic [3:0]              pc_address,
  output logic                    pc_write,
  output logic                    pc_begintransfer,
  output logic [31:0]             pc_writedata,
  input  logic [31:0]             pc_readdata,
  output logic                    cap_valid,
  input  logic                    cap_ready,
  output logic [1:0]              cap_section,
  output logic [63:0]             cap_time,
  output logic [31:0]             cap_events,
  output logic                    ovf,
  output logic                    busy
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEC_W  = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SEC0  = 3'd1,
    WR       = 3'd2,
    RD_LO    = 3'd3,
    RD_HI    = 3'd4,
    RD_EV    = 3'd5,
    RD_FIN   = 3'd6,
    CAP_WAIT = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_STOP = 2'd1,
    OP_GO   = 2'd2
  } op_t;

  state_t state, state_d;
  op_t    op, op_d;
  logic [SEC_W-1:0] sec, sec_d;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              write_d;

  logic [NUM_SECTIONS-1:0] pend_start, pend_start_d;
  logic [NUM_SECTIONS-1:0] pend_stop, pend_stop_d;
  logic                    pend_clr, pend_clr_d;
  logic [NUM_SECTIONS-1:0] running, running_d;
  logic                    ovf_d;

  logic [NUM_SECTIONS-1:0] served_hot, go_mask, stop_mask;
  logic [NUM_SECTIONS-1:0] start_kept, stop_kept;
  logic                    clr_served, clr_kept, drop;

  // Lowest-index set bit of a request vector.
  function automatic logic [SEC_W-1:0] lowest(input logic [NUM_SECTIONS-1:0] v);
    logic [SEC_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
      if (v[i] && !found) begin
        idx   = SEC_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // State and registered bus/capture-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      op               <= OP_CLR;
      sec              <= '0;
      pc_address       <= '0;
      pc_write         <= 1'b0;
      pc_begintransfer <= 1'b0;
      pc_writedata     <= '0;
      cap_valid        <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_d;
      op               <= op_d;
      sec              <= sec_d;
      pc_address       <= addr_d;
      pc_write         <= write_d;
      pc_begintransfer <= write_d;
      pc_writedata     <= wdata_d;
      cap_valid        <= (state_d == CAP_WAIT);
      busy             <= (state_d != IDLE);
    end
  end

  // Arbitration, sequencing and the bus values for the upcoming cycle.
  always_comb begin
    state_d = state;
    op_d    = op;
    sec_d   = sec;
    addr_d  = pc_address;
    write_d = 1'b0;
    wdata_d = '0;

    case (state)
      IDLE: begin
        // Clear beats stops beats starts, so a stop and start of the same
        // section pending together always close the old interval first.
        if (pend_clr) begin
          state_d = WR;
          op_d    = OP_CLR;
          sec_d   = '0;
        end else if (|pend_stop) begin
          state_d = WR;
          op_d    = OP_STOP;
          sec_d   = lowest(pend_stop);
        end else if (|pend_start) begin
          op_d    = OP_GO;
          sec_d   = lowest(pend_start);
          // Section 0 gates the counter's global enable.
          state_d = (AUTO_SEC0 && (sec_d != '0) && !running[0]) ? WR_SEC0 : WR;
        end
      end
      WR_SEC0:  state_d = WR;
      WR:       state_d = (CAPTURE_ON_STOP && (op == OP_STOP)) ? RD_LO : IDLE;
      RD_LO:    state_d = RD_HI;
      RD_HI:    state_d = RD_EV;
      RD_EV:    state_d = RD_FIN;
      RD_FIN:   state_d = CAP_WAIT;
      CAP_WAIT: if (cap_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    case (state_d)
      WR_SEC0: begin
        write_d = 1'b1;
        addr_d  = ADDR_W'(1);
      end
      WR: begin
        write_d = 1'b1;
        case (op_d)
          OP_CLR: begin
            addr_d  = '0;
            wdata_d = DATA_W'(1);
          end
          OP_STOP: addr_d = {sec_d, 2'b00};
          default: addr_d = {sec_d, 2'b01};
        endcase
      end
      RD_LO:         addr_d = {sec_d, 2'b00};
      RD_HI:         addr_d = {sec_d, 2'b01};
      RD_EV, RD_FIN: addr_d = {sec_d, 2'b10};
      default: ;
    endcase
  end

  // Request latching, overflow detection and running flags. A served bit is
  // released at the end of its write cycle, so a pulse in that same cycle
  // simply re-arms it instead of counting as a drop.
  always_comb begin
    served_hot = '0;
    for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
      served_hot[i] = (sec == SEC_W'(i));
    end
    clr_served = (state == WR) && (op == OP_CLR);
    stop_mask  = ((state == WR) && (op == OP_STOP)) ? served_hot : '0;
    go_mask    = ((state == WR) && (op == OP_GO))   ? served_hot : '0;

    start_kept = clr_served ? '0 : (pend_start & ~go_mask);
    stop_kept  = clr_served ? '0 : (pend_stop & ~stop_mask);
    clr_kept   = pend_clr & ~clr_served;

    pend_start_d = start_kept | evt_start;
    pend_stop_d  = stop_kept | evt_stop;
    pend_clr_d   = clr_kept | clr;

    drop  = (|(evt_start & start_kept)) | (|(evt_stop & stop_kept)) | (clr & clr_kept);
    ovf_d = (ovf & ~clr_served) | drop;

    running_d = clr_served ? '0 : ((running | go_mask) & ~stop_mask);
    if (state == WR_SEC0) running_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_start <= '0;
      pend_stop  <= '0;
      pend_clr   <= 1'b0;
      running    <= '0;
      ovf        <= 1'b0;
    end else begin
      pend_start <= pend_start_d;
      pend_stop  <= pend_stop_d;
      pend_clr   <= pend_clr_d;
      running    <= running_d;
      ovf        <= ovf_d;
    end
  end

  // Readback capture: readdata lags the driven address by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_section <= '0;
      cap_time    <= '0;
      cap_events  <= '0;
    end else begin
      case (state)
        RD_HI: begin
          cap_time[31:0] <= pc_readdata;
          cap_section    <= sec;
        end
        RD_EV:   cap_time[63:32] <= pc_readdata;
        RD_FIN:  cap_events      <= pc_readdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_event_sequencer.sv
// Directed bench for perf_event_sequencer with a small counter-slave model.
module tb_perf_event_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  evt_start = '0;
  logic [3:0]  evt_stop = '0;
  logic        clr = 1'b0;
  logic [3:0]  pc_address;
  logic        pc_write;
  logic        pc_begintransfer;
  logic [31:0] pc_writedata;
  logic [31:0] pc_readdata;
  logic        cap_valid;
  logic        cap_ready = 1'b0;
  logic [1:0]  cap_section;
  logic [63:0] cap_time;
  logic [31:0] cap_events;
  logic        ovf;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  perf_event_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .evt_start        (evt_start),
    .evt_stop         (evt_stop),
    .clr              (clr),
    .pc_address       (pc_address),
    .pc_write         (pc_write),
    .pc_begintransfer (pc_begintransfer),
    .pc_writedata     (pc_writedata),
    .pc_readdata      (pc_readdata),
    .cap_valid        (cap_valid),
    .cap_ready        (cap_ready),
    .cap_section      (cap_section),
    .cap_time         (cap_time),
    .cap_events       (cap_events),
    .ovf              (ovf),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter slave model: time counts while the section and section 0 run,
  // events count go writes, addr 0 with data 1 clears everything.
  logic [63:0] m_time [4];
  logic [31:0] m_ev   [4];
  logic [3:0]  m_run;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < 4; s++) begin
        m_time[s] <= '0;
        m_ev[s]   <= '0;
      end
      m_run       <= '0;
      pc_readdata <= '0;
    end else begin
      for (int s = 0; s < 4; s++)
        if (m_run[s] && m_run[0]) m_time[s] <= m_time[s] + 64'd1;
      if (pc_write) begin
        if (pc_address == 4'd0 && pc_writedata == 32'd1) begin
          for (int s = 0; s < 4; s++) begin
            m_time[s] <= '0;
            m_ev[s]   <= '0;
          end
          m_run <= '0;
        end else if (pc_address[1:0] == 2'd0) begin
          m_run[pc_address[3:2]] <= 1'b0;
        end else if (pc_address[1:0] == 2'd1) begin
          m_run[pc_address[3:2]] <= 1'b1;
          m_ev[pc_address[3:2]]  <= m_ev[pc_address[3:2]] + 32'd1;
        end
      end
      case (pc_address[1:0])
        2'd0:    pc_readdata <= m_time[pc_address[3:2]][31:0];
        2'd1:    pc_readdata <= m_time[pc_address[3:2]][63:32];
        2'd2:    pc_readdata <= m_ev[pc_address[3:2]];
        default: pc_readdata <= '0;
      endcase
    end
  end

  // Logs of bus writes and accepted capture records.
  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        bt;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [1:0]  sec;
    logic [63:0] tm;
    logic [31:0] ev;
  } cap_t;

  wr_t  wq[$];
  cap_t caps[$];
  wr_t  w_tmp;
  cap_t c_tmp;

  always @(negedge clk) begin
    if (pc_write) begin
      w_tmp.cyc  = cyc;
      w_tmp.addr = pc_address;
      w_tmp.data = pc_writedata;
      w_tmp.bt   = pc_begintransfer;
      wq.push_back(w_tmp);
    end
    if (cap_valid && cap_ready) begin
      c_tmp.cyc = cyc;
      c_tmp.sec = cap_section;
      c_tmp.tm  = cap_time;
      c_tmp.ev  = cap_events;
      caps.push_back(c_tmp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [3:0] st, input logic [3:0] sp, input logic c);
    evt_start = st;
    evt_stop  = sp;
    clr       = c;
    tick();
    evt_start = '0;
    evt_stop  = '0;
    clr       = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ticks(3);
    reset_n = 1'b1;
    ticks(10);
    n_tests++;
    if ({pc_write, pc_begintransfer, cap_valid, ovf, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {pc_write, pc_begintransfer, cap_valid, ovf, busy});
    end
    n_tests++;
    if ({pc_address, pc_writedata} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %0h data %0h expected 0 0", pc_address, pc_writedata);
    end
    n_tests++;
    if ({cap_section, cap_time, cap_events} !== 98'h0) begin
      n_fail++;
      $display("FAIL reset_capture: got sec %0d time %0h ev %0h expected 0", cap_section, cap_time, cap_events);
    end
    n_tests++;
    if (wq.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_no_write: got %0d writes expected 0", wq.size());
    end
  endtask

  task automatic test_single();
    wq.delete();
    caps.delete();
    cap_ready = 1'b1;
    pulse(4'b0001, 4'b0000, 1'b0);
    ticks(99);
    pulse(4'b0000, 4'b0001, 1'b0);
    for (int i = 0; i < 40 && caps.size() < 1; i++) tick();
    ticks(2);
    n_tests++;
    if (wq.size() !== 2) begin
      n_fail++;
      $display("FAIL single_write_count: got %0d expected 2", wq.size());
    end
    if (wq.size() >= 2) begin
      n_tests++;
      if ({wq[0].addr, wq[0].data, wq[0].bt} !== {4'd1, 32'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL single_go: got addr %0d data %0h bt %b expected 1 0 1", wq[0].addr, wq[0].data, wq[0].bt);
      end
      n_tests++;
      if ({wq[1].addr, wq[1].data} !== {4'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL single_stop: got addr %0d data %0h expected 0 0", wq[1].addr, wq[1].data);
      end
      n_tests++;
      if (wq[1].cyc - wq[0].cyc !== 100) begin
        n_fail++;
        $display("FAIL single_spacing: got %0d expected 100", wq[1].cyc - wq[0].cyc);
      end
    end
    n_tests++;
    if (caps.size() !== 1) begin
      n_fail++;
      $display("FAIL single_cap_count: got %0d expected 1", caps.size());
    end
    if (caps.size() >= 1 && wq.size() >= 2) begin
      n_tests++;
      if (caps[0].sec !== 2'd0 || caps[0].ev !== 32'd1) begin
        n_fail++;
        $display("FAIL single_cap_rec: got sec %0d ev %0d expected 0 1", caps[0].sec, caps[0].ev);
      end
      n_tests++;
      if (caps[0].tm < 64'd100 || caps[0].tm > 64'd102) begin
        n_fail++;
        $display("FAIL single_cap_time: got %0d expected 100..102", caps[0].tm);
      end
      n_tests++;
      if (caps[0].cyc - wq[1].cyc !== 5) begin
        n_fail++;
        $display("FAIL single_cap_latency: got %0d expected 5", caps[0].cyc - wq[1].cyc);
      end
    end
    n_tests++;
    if ({cap_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: got valid/busy %b expected 00", {cap_valid, busy});
    end
  endtask

  task automatic test_auto_sec0();
    wq.delete();
    pulse(4'b0100, 4'b0000, 1'b0);
    ticks(10);
    n_tests++;
    if (wq.size() !== 2) begin
      n_fail++;
      $display("FAIL auto_write_count: got %0d expected 2", wq.size());
    end
    if (wq.size() >= 2) begin
      n_tests++;
      if ({wq[0].addr, wq[1].addr} !== {4'd1, 4'd9}) begin
        n_fail++;
        $display("FAIL auto_addrs: got %0d,%0d expected 1,9", wq[0].addr, wq[1].addr);
      end
      n_tests++;
      if (wq[1].cyc - wq[0].cyc !== 1) begin
        n_fail++;
        $display("FAIL auto_b2b: got %0d expected 1", wq[1].cyc - wq[0].cyc);
      end
    end
    // Section 0 now runs, so section 3 starts with a single go.
    pulse(4'b1000, 4'b0000, 1'b0);
    ticks(10);
    n_tests++;
    if (wq.size() !== 3) begin
      n_fail++;
      $display("FAIL auto_no_repeat_count: got %0d expected 3", wq.size());
    end
    if (wq.size() >= 3) begin
      n_tests++;
      if (wq[2].addr !== 4'd13) begin
        n_fail++;
        $display("FAIL auto_sec3_go: got %0d expected 13", wq[2].addr);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [3:0] exp_addr [4];
    bit found;
    exp_addr[0] = 4'd4;
    exp_addr[1] = 4'd5;
    exp_addr[2] = 4'd6;
    exp_addr[3] = 4'd6;
    wq.delete();
    caps.delete();
    pulse(4'b0010, 4'b0010, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (pc_write && pc_address == 4'd4) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL same_stop_write: got none expected write at addr 4");
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (pc_address !== exp_addr[k] || pc_write !== 1'b0) begin
        n_fail++;
        $display("FAIL same_readback_%0d: got addr %0d wr %b expected %0d 0", k, pc_address, pc_write, exp_addr[k]);
      end
    end
    ticks(20);
    n_tests++;
    if (wq.size() !== 2) begin
      n_fail++;
      $display("FAIL same_write_count: got %0d expected 2", wq.size());
    end
    if (wq.size() >= 2) begin
      n_tests++;
      if ({wq[0].addr, wq[1].addr} !== {4'd4, 4'd5}) begin
        n_fail++;
        $display("FAIL same_order: got %0d,%0d expected 4,5", wq[0].addr, wq[1].addr);
      end
    end
    n_tests++;
    if (caps.size() !== 1) begin
      n_fail++;
      $display("FAIL same_cap_count: got %0d expected 1", caps.size());
    end
    if (caps.size() >= 1) begin
      n_tests++;
      if (caps[0].sec !== 2'd1 || caps[0].tm !== 64'd0 || caps[0].ev !== 32'd0) begin
        n_fail++;
        $display("FAIL same_cap_rec: got sec %0d time %0d ev %0d expected 1 0 0", caps[0].sec, caps[0].tm, caps[0].ev);
      end
    end
    n_tests++;
    if (pc_address !== 4'd5) begin
      n_fail++;
      $display("FAIL same_addr_hold: got %0d expected 5", pc_address);
    end
  endtask

  task automatic test_backpressure();
    wq.delete();
    caps.delete();
    cap_ready = 1'b0;
    pulse(4'b0000, 4'b0100, 1'b0);
    ticks(12);
    pulse(4'b0000, 4'b1000, 1'b0);
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first_pending: got ovf %b expected 0", ovf);
    end
    pulse(4'b0000, 4'b1000, 1'b0);
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second_ovf: got ovf %b expected 1", ovf);
    end
    ticks(6);
    n_tests++;
    if ({cap_valid, busy, cap_section} !== {1'b1, 1'b1, 2'd2} || caps.size() !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got valid %b busy %b sec %0d recs %0d expected 1 1 2 0", cap_valid, busy, cap_section, caps.size());
    end
    cap_ready = 1'b1;
    for (int i = 0; i < 40 && caps.size() < 2; i++) tick();
    ticks(3);
    n_tests++;
    if (caps.size() !== 2 || wq.size() !== 2) begin
      n_fail++;
      $display("FAIL bp_counts: got caps %0d writes %0d expected 2 2", caps.size(), wq.size());
    end
    if (caps.size() >= 2 && wq.size() >= 2) begin
      n_tests++;
      if ({caps[0].sec, caps[1].sec} !== {2'd2, 2'd3}) begin
        n_fail++;
        $display("FAIL bp_cap_order: got %0d,%0d expected 2,3", caps[0].sec, caps[1].sec);
      end
      n_tests++;
      if ({caps[0].ev, caps[1].ev} !== {32'd1, 32'd1}) begin
        n_fail++;
        $display("FAIL bp_cap_events: got %0d,%0d expected 1,1", caps[0].ev, caps[1].ev);
      end
      n_tests++;
      if ({wq[0].addr, wq[1].addr} !== {4'd8, 4'd12}) begin
        n_fail++;
        $display("FAIL bp_stop_addrs: got %0d,%0d expected 8,12", wq[0].addr, wq[1].addr);
      end
    end
  endtask

  task automatic test_clr();
    wq.delete();
    caps.delete();
    cap_ready = 1'b0;
    pulse(4'b0000, 4'b0010, 1'b0);
    ticks(12);
    pulse(4'b0100, 4'b0000, 1'b0);
    pulse(4'b0000, 4'b0000, 1'b1);
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_ovf_before: got %b expected 1", ovf);
    end
    cap_ready = 1'b1;
    ticks(20);
    n_tests++;
    if (wq.size() !== 2 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_result: got writes %0d ovf %b expected 2 0", wq.size(), ovf);
    end
    if (wq.size() >= 2) begin
      n_tests++;
      if ({wq[1].addr, wq[1].data} !== {4'd0, 32'd1}) begin
        n_fail++;
        $display("FAIL clr_write: got addr %0d data %0h expected 0 1", wq[1].addr, wq[1].data);
      end
    end
    // Clear dropped all running flags, so section 3 needs section 0 again.
    pulse(4'b1000, 4'b0000, 1'b0);
    ticks(10);
    n_tests++;
    if (wq.size() !== 4) begin
      n_fail++;
      $display("FAIL clr_restart_count: got %0d expected 4", wq.size());
    end
    if (wq.size() >= 4) begin
      n_tests++;
      if ({wq[2].addr, wq[3].addr} !== {4'd1, 4'd13} || wq[3].cyc - wq[2].cyc !== 1) begin
        n_fail++;
        $display("FAIL clr_restart_auto: got %0d,%0d gap %0d expected 1,13 gap 1", wq[2].addr, wq[3].addr, wq[3].cyc - wq[2].cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    cap_ready = 1'b1;
    pulse(4'b0000, 4'b1000, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (pc_write && pc_address == 4'd12) found = 1'b1;
    end
    ticks(2);
    n_tests++;
    if (!found || pc_address !== 4'd13 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rd_hi: got found %b addr %0d busy %b expected 1 13 1", found, pc_address, busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({pc_write, pc_begintransfer, cap_valid, ovf, busy, pc_address, pc_writedata, cap_time} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got wr %b valid %b busy %b addr %0d time %0h expected all 0", pc_write, cap_valid, busy, pc_address, cap_time);
    end
    ticks(2);
    reset_n = 1'b1;
    wq.delete();
    ticks(10);
    n_tests++;
    if (wq.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after_reset: got writes %0d busy %b expected 0 0", wq.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_auto_sec0();
    test_same_cycle();
    test_backpressure();
    test_clr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
